// File: rtl/lrelu_pkg.sv
// Shared constants for the leaky-ReLU stream stage: activation mode encodings
// and the configuration values restored on reset.
package lrelu_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BYPASS = 2'b00;
  localparam mode_t MODE_RELU   = 2'b01;
  localparam mode_t MODE_LEAKY  = 2'b10;
  localparam mode_t MODE_CLIP   = 2'b11;

  localparam mode_t DEF_MODE  = MODE_LEAKY;
  // ~0.1 with 12 fractional bits
  localparam int    DEF_COEF  = 410;

endpackage

// File: rtl/lrelu_lane.sv
// One activation lane: S2 forms the scaled product, S3 rounds, saturates and
// applies the optional upper clip. sat flags the value being loaded into S3.
module lrelu_lane
  import lrelu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ld2,
  input  logic                  ld3,
  input  logic [DATA_WIDTH-1:0] x,
  input  mode_t                 mode1,
  input  logic [COEF_WIDTH-1:0] coef,
  input  mode_t                 mode2,
  input  logic [DATA_WIDTH-1:0] clip2,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  sat
);

  localparam int PW     = DATA_WIDTH + COEF_WIDTH;
  localparam int YMAX_I = (1 << (DATA_WIDTH - 1)) - 1;
  localparam logic signed [PW:0] YMAX = (PW+1)'(YMAX_I);
  localparam logic signed [PW:0] YMIN = (PW+1)'(-YMAX_I - 1);

  logic signed [PW-1:0]         xe, ce, p_d, p_q;
  logic signed [PW:0]           rnd, sh;
  logic signed [DATA_WIDTH-1:0] y_sat, y_d, y_q;
  logic                         sat_d;

  // Non-scaled paths are pre-shifted so S3 treats every mode identically.
  always_comb begin
    xe  = {{COEF_WIDTH{x[DATA_WIDTH-1]}}, x};
    ce  = {{DATA_WIDTH{coef[COEF_WIDTH-1]}}, coef};
    p_d = xe <<< COEF_FRAC;
    if (x[DATA_WIDTH-1]) begin
      if (mode1 == MODE_LEAKY || mode1 == MODE_CLIP) begin
        p_d = xe * ce;
      end else if (mode1 == MODE_RELU) begin
        p_d = '0;
      end
    end
  end

  always_comb begin
    rnd   = {p_q[PW-1], p_q} + (PW+1)'(1 << (COEF_FRAC - 1));
    sh    = rnd >>> COEF_FRAC;
    sat_d = 1'b0;
    y_sat = sh[DATA_WIDTH-1:0];
    if (sh > YMAX) begin
      y_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat_d = 1'b1;
    end else if (sh < YMIN) begin
      y_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat_d = 1'b1;
    end
    y_d = y_sat;
    if (mode2 == MODE_CLIP && y_sat > $signed(clip2)) begin
      y_d = clip2;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q <= '0;
      y_q <= '0;
    end else begin
      if (ld2) p_q <= p_d;
      if (ld3) y_q <= y_d;
    end
  end

  assign y   = y_q;
  assign sat = sat_d;

endmodule

// File: rtl/lrelu_stream_pipe.sv
// Multi-lane 3-stage activation pipeline with valid/ready backpressure.
// Optional saturation counter enabled by defining LRELU_SAT_COUNT_EN.
module lrelu_stream_pipe
  import lrelu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int UNITS      = 4,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 12
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic                        cfg_load,
  input  logic [1:0]                  cfg_mode,
  input  logic [COEF_WIDTH-1:0]       cfg_coef,
  input  logic [DATA_WIDTH-1:0]       cfg_clip,
  input  logic                        l_valid,
  output logic                        l_rdy,
  input  logic [DATA_WIDTH*UNITS-1:0] d_in,
  input  logic                        T_last_in,
  output logic                        r_valid,
  input  logic                        r_rdy,
  output logic [DATA_WIDTH*UNITS-1:0] d_out,
  output logic                        T_last_out
`ifdef LRELU_SAT_COUNT_EN
  , output logic [31:0]               sat_cnt
`endif
);

  localparam logic [DATA_WIDTH-1:0] CLIP_RST = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  mode_t                        mode_q, mode1_q, mode2_q;
  logic [COEF_WIDTH-1:0]        coef_q, coef1_q;
  logic [DATA_WIDTH-1:0]        clip_q, clip1_q, clip2_q;
  logic [DATA_WIDTH*UNITS-1:0]  d1_q;
  logic                         v1_q, v2_q, v3_q;
  logic                         last1_q, last2_q, last3_q;
  logic                         rdy1, rdy2, rdy3;
  logic                         ld1, ld2, ld3;
  logic [UNITS-1:0]             lane_sat;

  assign rdy3 = !v3_q || r_rdy;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;
  assign ld1  = rdy1 && l_valid;
  assign ld2  = rdy2 && v1_q;
  assign ld3  = rdy3 && v2_q;

  // Beats sample the config registers before a same-cycle cfg_load lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q  <= DEF_MODE;
      coef_q  <= COEF_WIDTH'(DEF_COEF);
      clip_q  <= CLIP_RST;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      d1_q    <= '0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
      mode1_q <= MODE_BYPASS;
      mode2_q <= MODE_BYPASS;
      coef1_q <= '0;
      clip1_q <= '0;
      clip2_q <= '0;
    end else begin
      if (cfg_load) begin
        mode_q <= cfg_mode;
        coef_q <= cfg_coef;
        clip_q <= cfg_clip;
      end
      if (rdy1) v1_q <= l_valid;
      if (ld1) begin
        d1_q    <= d_in;
        last1_q <= T_last_in;
        mode1_q <= en ? mode_q : MODE_BYPASS;
        coef1_q <= coef_q;
        clip1_q <= clip_q;
      end
      if (rdy2) v2_q <= v1_q;
      if (ld2) begin
        last2_q <= last1_q;
        mode2_q <= mode1_q;
        clip2_q <= clip1_q;
      end
      if (rdy3) v3_q <= v2_q;
      if (ld3) last3_q <= last2_q;
    end
  end

  for (genvar gi = 0; gi < UNITS; gi++) begin : g_lane
    lrelu_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .COEF_FRAC  (COEF_FRAC)
    ) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .ld2   (ld2),
      .ld3   (ld3),
      .x     (d1_q[gi*DATA_WIDTH +: DATA_WIDTH]),
      .mode1 (mode1_q),
      .coef  (coef1_q),
      .mode2 (mode2_q),
      .clip2 (clip2_q),
      .y     (d_out[gi*DATA_WIDTH +: DATA_WIDTH]),
      .sat   (lane_sat[gi])
    );
  end

  assign l_rdy      = rdy1;
  assign r_valid    = v3_q;
  assign T_last_out = last3_q;

`ifdef LRELU_SAT_COUNT_EN
  logic [31:0] sat_cnt_q, sat_cnt_d;
  logic [32:0] sat_sum;

  // Sticky at all-ones; a cfg_load clear wins over a same-cycle increment.
  always_comb begin
    sat_sum = {1'b0, sat_cnt_q};
    for (int i = 0; i < UNITS; i++) begin
      sat_sum = sat_sum + 33'(lane_sat[i]);
    end
    sat_cnt_d = sat_cnt_q;
    if (cfg_load) begin
      sat_cnt_d = '0;
    end else if (ld3) begin
      sat_cnt_d = sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = |lane_sat;
`endif

endmodule
